// File: rtl/vx_gpu_req_arb_pkg.sv
// Shared types for the GPU request arbiter: the packed request payload,
// its width, the arbitration type codes and a select-width helper.
package VX_gpu_pkg;

  localparam int NUM_THREADS = 4;
  localparam int XLEN        = 32;
  localparam int UUID_W      = 44;
  localparam int NW_BITS     = 2;
  localparam int NT_BITS     = 2;
  localparam int OP_TYPE_W   = 4;
  localparam int OP_MOD_W    = 3;
  localparam int REG_BITS    = 5;

  typedef struct packed {
    logic [UUID_W-1:0]                uuid;
    logic [NW_BITS-1:0]               wid;
    logic [NUM_THREADS-1:0]           tmask;
    logic [XLEN-1:0]                  PC;
    logic [XLEN-1:0]                  next_PC;
    logic [OP_TYPE_W-1:0]             op_type;
    logic [OP_MOD_W-1:0]              op_mod;
    logic [NT_BITS-1:0]               tid;
    logic [NUM_THREADS-1:0][XLEN-1:0] rs1_data;
    logic [NUM_THREADS-1:0][XLEN-1:0] rs2_data;
    logic [NUM_THREADS-1:0][XLEN-1:0] rs3_data;
    logic [REG_BITS-1:0]              rd;
    logic                             wb;
  } gpu_req_t;

  localparam int GPU_REQ_DATAW = $bits(gpu_req_t);

  localparam logic [7:0] ARB_RR   = "R";
  localparam logic [7:0] ARB_PRIO = "P";

  // A single channel still needs a one-bit select so that port widths stay legal.
  function automatic int arbIdxW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_gpu_req_arb_rr_grant.sv
// Combinational round-robin grant: scans requests starting just above the
// last-served index; a fixed last index of NUM_REQS-1 yields fixed priority.
module VX_rr_grant
  import VX_gpu_pkg::*;
#(
  parameter int  NUM_REQS = 4,
  localparam int IDXW     = arbIdxW(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] requests_i,
  input  logic [IDXW-1:0]     lastIdx_i,
  output logic [NUM_REQS-1:0] grantOh_o,
  output logic [IDXW-1:0]     grantIdx_o,
  output logic                grantValid_o
);

  assign grantValid_o = |requests_i;

  if (NUM_REQS == 1) begin : g_single
    logic unusedLast;
    assign unusedLast = ^lastIdx_i;
    assign grantOh_o  = requests_i;
    assign grantIdx_o = '0;
  end else begin : g_scan
    always_comb begin : scan
      logic [IDXW-1:0] cand;
      logic            found;
      int              pos;
      grantOh_o  = '0;
      grantIdx_o = '0;
      found      = 1'b0;
      cand       = '0;
      pos        = 0;
      for (int i = 0; i < NUM_REQS; i++) begin
        pos  = (int'(lastIdx_i) + 1 + i) % NUM_REQS;
        cand = IDXW'(pos);
        if (!found && requests_i[cand]) begin
          found           = 1'b1;
          grantOh_o[cand] = 1'b1;
          grantIdx_o      = cand;
        end
      end
    end
  end

endmodule

// File: rtl/vx_gpu_req_arb.sv
// N-channel GPU request arbiter with optional pipe/skid output stage.
// Define GPU_REQ_ARB_PERF_EN to add saturating stall/conflict counters.
module vx_gpu_req_arb
  import VX_gpu_pkg::*;
#(
  parameter int         NUM_REQS = 4,
  parameter int         DATAW    = GPU_REQ_DATAW,
  parameter logic [7:0] ARB_TYPE = ARB_RR,
  parameter int         BUFFERED = 1,
  localparam int        SELW     = arbIdxW(NUM_REQS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       valid_in,
  input  logic [NUM_REQS*DATAW-1:0] data_in,
  output logic [NUM_REQS-1:0]       ready_in,
  output logic                      valid_out,
  output logic [DATAW-1:0]          data_out,
  output logic [SELW-1:0]           sel_out,
  input  logic                      ready_out
`ifdef GPU_REQ_ARB_PERF_EN
  ,
  output logic [43:0]               perf_stalls,
  output logic [43:0]               perf_conflicts
`endif
);

  logic [NUM_REQS-1:0] grantOh;
  logic [SELW-1:0]     grantIdx;
  logic [SELW-1:0]     arbLast;
  logic                grantValid;
  logic [DATAW-1:0]    grantData;
  logic                stageReady;
  logic                inFire;

  assign inFire = |(valid_in & ready_in);

  if (ARB_TYPE == ARB_RR && NUM_REQS > 1) begin : g_rr
    logic [SELW-1:0] lastIdx_q, lastIdx_d;
    assign lastIdx_d = inFire ? grantIdx : lastIdx_q;
    always_ff @(posedge clk) begin
      if (reset) lastIdx_q <= SELW'(NUM_REQS - 1);
      else       lastIdx_q <= lastIdx_d;
    end
    assign arbLast = lastIdx_q;
  end else begin : g_fixed
    assign arbLast = SELW'(NUM_REQS - 1);
  end

  VX_rr_grant #(.NUM_REQS(NUM_REQS)) grantUnit (
    .requests_i   (valid_in),
    .lastIdx_i    (arbLast),
    .grantOh_o    (grantOh),
    .grantIdx_o   (grantIdx),
    .grantValid_o (grantValid)
  );

  always_comb begin
    grantData = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grantOh[i]) grantData = grantData | data_in[i*DATAW +: DATAW];
    end
  end

  assign ready_in = grantOh & {NUM_REQS{stageReady}};

  if (BUFFERED == 0) begin : g_pass
    assign stageReady = ready_out;
    assign valid_out  = grantValid;
    assign data_out   = grantData;
    assign sel_out    = grantIdx;
  end else if (BUFFERED == 1) begin : g_pipe
    logic             valid_q, valid_d;
    logic [DATAW-1:0] data_q, data_d;
    logic [SELW-1:0]  sel_q, sel_d;

    assign stageReady = !valid_q || ready_out;

    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      sel_d   = sel_q;
      if (stageReady) begin
        valid_d = grantValid;
        data_d  = grantData;
        sel_d   = grantIdx;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        sel_q   <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
        sel_q   <= sel_d;
      end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign sel_out   = sel_q;
  end else begin : g_skid
    logic             mainValid_q, mainValid_d, skidValid_q, skidValid_d;
    logic [DATAW-1:0] mainData_q, mainData_d, skidData_q, skidData_d;
    logic [SELW-1:0]  mainSel_q, mainSel_d, skidSel_q, skidSel_d;

    // Input side only looks at the skid flop, so ready_out never reaches ready_in.
    assign stageReady = !skidValid_q && !reset;

    always_comb begin
      mainValid_d = mainValid_q;
      mainData_d  = mainData_q;
      mainSel_d   = mainSel_q;
      skidValid_d = skidValid_q;
      skidData_d  = skidData_q;
      skidSel_d   = skidSel_q;
      if (!mainValid_q || ready_out) begin
        if (skidValid_q) begin
          mainValid_d = 1'b1;
          mainData_d  = skidData_q;
          mainSel_d   = skidSel_q;
          skidValid_d = 1'b0;
        end else begin
          mainValid_d = inFire;
          mainData_d  = grantData;
          mainSel_d   = grantIdx;
        end
      end else if (inFire) begin
        skidValid_d = 1'b1;
        skidData_d  = grantData;
        skidSel_d   = grantIdx;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        mainValid_q <= 1'b0;
        mainData_q  <= '0;
        mainSel_q   <= '0;
        skidValid_q <= 1'b0;
        skidData_q  <= '0;
        skidSel_q   <= '0;
      end else begin
        mainValid_q <= mainValid_d;
        mainData_q  <= mainData_d;
        mainSel_q   <= mainSel_d;
        skidValid_q <= skidValid_d;
        skidData_q  <= skidData_d;
        skidSel_q   <= skidSel_d;
      end
    end

    assign valid_out = mainValid_q;
    assign data_out  = mainData_q;
    assign sel_out   = mainSel_q;
  end

`ifdef GPU_REQ_ARB_PERF_EN
  logic [43:0] stalls_q, stalls_d, conflicts_q, conflicts_d;

  always_comb begin
    stalls_d    = stalls_q;
    conflicts_d = conflicts_q;
    if (valid_out && !ready_out && !(&stalls_q)) stalls_d = stalls_q + 44'd1;
    if (($countones(valid_in) > 1) && !(&conflicts_q)) conflicts_d = conflicts_q + 44'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stalls_q    <= '0;
      conflicts_q <= '0;
    end else begin
      stalls_q    <= stalls_d;
      conflicts_q <= conflicts_d;
    end
  end

  assign perf_stalls    = stalls_q;
  assign perf_conflicts = conflicts_q;
`endif

endmodule

// File: tb/tb_vx_gpu_req_arb.sv
// Bench for vx_gpu_req_arb: three instances (R/pipe, P/pass-through, R/skid)
// checked every cycle against a queue-based model, plus directed scenarios.
module tb_vx_gpu_req_arb;
  import VX_gpu_pkg::*;

  localparam int DW = GPU_REQ_DATAW;
  localparam int NR = 4;
  localparam int BUFM [3] = '{1, 0, 2};
  localparam bit ISRR [3] = '{1'b1, 1'b0, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [NR-1:0]    vIn [3];
  logic             rOut [3];
  logic [DW-1:0]    pay [3][NR];
  logic [NR*DW-1:0] dIn [3];
  logic [NR-1:0]    rIn [3];
  logic             vOut [3];
  logic [DW-1:0]    dOut [3];
  logic [1:0]       sOut [3];
`ifdef GPU_REQ_ARB_PERF_EN
  logic [43:0]      pStalls [3];
  logic [43:0]      pConflicts [3];
`endif

  assign dIn[0] = {pay[0][3], pay[0][2], pay[0][1], pay[0][0]};
  assign dIn[1] = {pay[1][3], pay[1][2], pay[1][1], pay[1][0]};
  assign dIn[2] = {pay[2][3], pay[2][2], pay[2][1], pay[2][0]};

  vx_gpu_req_arb #(.NUM_REQS(NR), .DATAW(DW), .ARB_TYPE("R"), .BUFFERED(1)) dutRPipe (
    .clk(clk), .reset(reset), .valid_in(vIn[0]), .data_in(dIn[0]), .ready_in(rIn[0]),
    .valid_out(vOut[0]), .data_out(dOut[0]), .sel_out(sOut[0]), .ready_out(rOut[0])
`ifdef GPU_REQ_ARB_PERF_EN
    , .perf_stalls(pStalls[0]), .perf_conflicts(pConflicts[0])
`endif
  );

  vx_gpu_req_arb #(.NUM_REQS(NR), .DATAW(DW), .ARB_TYPE("P"), .BUFFERED(0)) dutPPass (
    .clk(clk), .reset(reset), .valid_in(vIn[1]), .data_in(dIn[1]), .ready_in(rIn[1]),
    .valid_out(vOut[1]), .data_out(dOut[1]), .sel_out(sOut[1]), .ready_out(rOut[1])
`ifdef GPU_REQ_ARB_PERF_EN
    , .perf_stalls(pStalls[1]), .perf_conflicts(pConflicts[1])
`endif
  );

  vx_gpu_req_arb #(.NUM_REQS(NR), .DATAW(DW), .ARB_TYPE("R"), .BUFFERED(2)) dutRSkid (
    .clk(clk), .reset(reset), .valid_in(vIn[2]), .data_in(dIn[2]), .ready_in(rIn[2]),
    .valid_out(vOut[2]), .data_out(dOut[2]), .sel_out(sOut[2]), .ready_out(rOut[2])
`ifdef GPU_REQ_ARB_PERF_EN
    , .perf_stalls(pStalls[2]), .perf_conflicts(pConflicts[2])
`endif
  );

  // Model: last-served channel per arbiter and an in-order list of buffered requests.
  int            lastM [3];
  int            cnt [3];
  int            memSel [3][2];
  logic [DW-1:0] memData [3][2];
  int            firedCh [3];
  int            outCount [3];
  int            accCount [3];
  int            obsSel0 [$];
  int            p1Other;
  int            compared;
  int            mismatched;

  function automatic logic [DW-1:0] randPayload();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < (DW + 31) / 32; i++) r = (r << 32) | DW'($urandom);
    return r;
  endfunction

  function automatic int expGrant(input logic [NR-1:0] v, input int last, input bit rr);
    int start;
    start = rr ? (last + 1) % NR : 0;
    for (int off = 0; off < NR; off++) begin
      if (v[(start + off) % NR]) return (start + off) % NR;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setAll(input logic [NR-1:0] v, input logic r);
    for (int k = 0; k < 3; k++) begin
      vIn[k]  = v;
      rOut[k] = r;
    end
  endtask

  task automatic applyReset(input int cycles);
    reset = 1'b1;
    setAll(4'b1111, 1'b0);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      checkOutput("d0.valid_out.reset", DW'(vOut[0]), DW'(0));
      checkOutput("d2.valid_out.reset", DW'(vOut[2]), DW'(0));
      checkOutput("d2.ready_in.reset", DW'(rIn[2]), DW'(0));
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cnt[k]      = 0;
      lastM[k]    = NR - 1;
      firedCh[k]  = -1;
      outCount[k] = 0;
      accCount[k] = 0;
    end
    obsSel0.delete();
    p1Other = 0;
  endtask

  // One clock: compare at the falling edge, then advance the model past the rising edge.
  task automatic applyStimulus();
    int            gA [3];
    bit            inFA [3];
    bit            outFA [3];
    bit            acc;
    logic [NR-1:0] expReady;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      gA[k] = expGrant(vIn[k], lastM[k], ISRR[k]);
      if (BUFM[k] == 0)      acc = rOut[k];
      else if (BUFM[k] == 1) acc = (cnt[k] == 0) || rOut[k];
      else                   acc = (cnt[k] < 2);
      inFA[k]  = (gA[k] >= 0) && acc;
      expReady = inFA[k] ? NR'(1 << gA[k]) : '0;
      checkOutput($sformatf("d%0d.ready_in", k), DW'(rIn[k]), DW'(expReady));
      if (BUFM[k] == 0) begin
        checkOutput($sformatf("d%0d.valid_out", k), DW'(vOut[k]), DW'(gA[k] >= 0));
        if (gA[k] >= 0) begin
          checkOutput($sformatf("d%0d.sel_out", k), DW'(sOut[k]), DW'(gA[k]));
          checkOutput($sformatf("d%0d.data_out", k), dOut[k], pay[k][gA[k]]);
        end
        outFA[k] = inFA[k];
      end else begin
        checkOutput($sformatf("d%0d.valid_out", k), DW'(vOut[k]), DW'(cnt[k] > 0));
        if (cnt[k] > 0) begin
          checkOutput($sformatf("d%0d.sel_out", k), DW'(sOut[k]), DW'(memSel[k][0]));
          checkOutput($sformatf("d%0d.data_out", k), dOut[k], memData[k][0]);
        end
        outFA[k] = (cnt[k] > 0) && rOut[k];
      end
      if (vOut[k] && rOut[k]) begin
        outCount[k]++;
        if (k == 0) obsSel0.push_back(int'(sOut[0]));
        if (k == 1 && sOut[1] != 2'd1) p1Other++;
      end
      if (rIn[k] != '0) accCount[k]++;
      firedCh[k] = inFA[k] ? gA[k] : -1;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (BUFM[k] != 0) begin
        if (outFA[k]) begin
          memSel[k][0]  = memSel[k][1];
          memData[k][0] = memData[k][1];
          cnt[k]--;
        end
        if (inFA[k]) begin
          memSel[k][cnt[k]]  = gA[k];
          memData[k][cnt[k]] = pay[k][gA[k]];
          cnt[k]++;
        end
      end
      if (ISRR[k] && inFA[k]) lastM[k] = gA[k];
      if (inFA[k]) pay[k][gA[k]] = randPayload();
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    for (int k = 0; k < 3; k++) begin
      for (int ch = 0; ch < NR; ch++) pay[k][ch] = randPayload();
    end
    applyReset(2);

    // Round-robin rotation with every channel valid and no back-pressure.
    setAll(4'b1111, 1'b1);
    repeat (7) applyStimulus();
    checkOutput("t1.count", DW'(obsSel0.size()), DW'(6));
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("t1.sel%0d", i),
                  DW'((i < obsSel0.size()) ? obsSel0[i] : -1), DW'(i % 4));
    end

    // Fixed priority: channel 1 always beats channel 3.
    p1Other     = 0;
    outCount[1] = 0;
    setAll(4'b1010, 1'b1);
    repeat (5) applyStimulus();
    checkOutput("t2.count", DW'(outCount[1]), DW'(5));
    checkOutput("t2.starve", DW'(p1Other), DW'(0));

    // Skid absorbs exactly one extra request after the stall, then drains in order.
    setAll(4'b0100, 1'b1);
    repeat (3) applyStimulus();
    setAll(4'b0100, 1'b0);
    accCount[2] = 0;
    repeat (5) applyStimulus();
    checkOutput("t3.absorbed", DW'(accCount[2]), DW'(1));
    outCount[2] = 0;
    setAll(4'b0000, 1'b1);
    repeat (3) applyStimulus();
    checkOutput("t3.drained", DW'(outCount[2]), DW'(2));

    // Pointer wrap: channel 0 first, then channel 3.
    applyReset(1);
    setAll(4'b0001, 1'b0);
    repeat (3) applyStimulus();
    setAll(4'b1001, 1'b1);
    repeat (3) applyStimulus();
    checkOutput("t4.first", DW'((obsSel0.size() > 0) ? obsSel0[0] : -1), DW'(0));
    checkOutput("t4.second", DW'((obsSel0.size() > 1) ? obsSel0[1] : -1), DW'(3));

    // Reset with the skid full, then first grant after release.
    setAll(4'b0100, 1'b0);
    repeat (3) applyStimulus();
    applyReset(1);
    setAll(4'b1111, 1'b1);
    repeat (2) applyStimulus();
    checkOutput("t5.first", DW'((obsSel0.size() > 0) ? obsSel0[0] : -1), DW'(0));

`ifdef GPU_REQ_ARB_PERF_EN
    applyReset(1);
    setAll(4'b0011, 1'b0);
    repeat (10) applyStimulus();
    checkOutput("perf.stalls", DW'(pStalls[1]), DW'(10));
    checkOutput("perf.conflicts", DW'(pConflicts[1]), DW'(10));
`endif

    // Random traffic: requests stay up until accepted, ready_out toggles freely.
    $display("[TB] random phase");
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < 3; k++) begin
        rOut[k] = ($urandom_range(0, 9) < 7);
        for (int ch = 0; ch < NR; ch++) begin
          if (firedCh[k] == ch)  vIn[k][ch] = 1'($urandom_range(0, 1));
          else if (!vIn[k][ch])  vIn[k][ch] = ($urandom_range(0, 9) < 4);
        end
      end
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
